// File: rtl/accelerator_common_pkg.sv
// Shared accelerator types: the 256-bit DMA descriptor layout and its
// field/flag positions, plus the range-end helper used by descriptor intake.
package accelerator_common_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int DESC_BITS     = 256;
    localparam int DESC_BEATS_32 = 8;
    localparam int DESC_BEATS_64 = 4;

    // Bit positions inside descriptor_t.flags
    localparam int FLAG_IRQ   = 0;
    localparam int FLAG_CHAIN = 1;
    localparam int FLAG_WRITE = 2;

    typedef struct packed {
        logic [63:0]  dram_addr;   // [255:192]
        logic [15:0]  sram_addr;   // [191:176]
        logic [15:0]  length;      // [175:160]
        logic [7:0]   flags;       // [159:152]
        logic [151:0] reserved;    // [151:0]
    } descriptor_t;

    // One extra bit so 0xFFFF + 0xFFFF cannot wrap into a legal range.
    function automatic logic [16:0] range_end(input logic [15:0] addr, input logic [15:0] len);
        return {1'b0, addr} + {1'b0, len};
    endfunction

endpackage

// File: rtl/desc_fifo.sv
// Generic synchronous FIFO with a combinational head output so back-to-back
// entries drain without a bubble; clr empties it with priority over push/pop.
module desc_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_push = push && !full && !clr;
    assign do_pop  = pop && !empty && !clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/desc_queue.sv
// Descriptor intake: assembles WORD_W beats into 256-bit descriptors, rejects
// badly framed or out-of-range ones, and queues the rest for the consumer.
import accelerator_common_pkg::*;

module desc_queue #(
    parameter int WORD_W     = 32,
    parameter int DEPTH      = 4,
    parameter int SRAM_BYTES = 32768
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WORD_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output descriptor_t                  out_desc,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                         err_frame,
    output logic                         err_range,
    output logic [15:0]                  accepted_cnt
);

    localparam int BEATS = DESC_BITS / WORD_W;
    localparam int BCW   = $clog2(BEATS);

    logic [BCW-1:0]              beat_cnt_q, beat_cnt_d;
    logic [DESC_BITS-WORD_W-1:0] asm_q, asm_d;
    logic                        err_frame_q, err_frame_d;
    logic                        err_range_q, err_range_d;
    logic [15:0]                 accepted_cnt_q, accepted_cnt_d;

    descriptor_t asm_full;
    logic        final_slot;
    logic        beat;
    logic        range_bad;
    logic        push;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;

    // in_ready depends only on registered state, never on out_ready.
    assign final_slot = (beat_cnt_q == BCW'(BEATS - 1));
    assign in_ready   = !final_slot || !fifo_full;
    assign beat       = in_valid && in_ready;
    assign asm_full   = descriptor_t'({asm_q, in_data});
    assign range_bad  = (asm_full.length == '0) ||
                        (range_end(asm_full.sram_addr, asm_full.length) > 17'(SRAM_BYTES));
    assign out_valid  = !fifo_empty;
    assign pop        = out_valid && out_ready;

    always_comb begin
        beat_cnt_d     = beat_cnt_q;
        asm_d          = asm_q;
        err_frame_d    = 1'b0;
        err_range_d    = 1'b0;
        accepted_cnt_d = accepted_cnt_q;
        push           = 1'b0;
        if (flush) begin
            beat_cnt_d = '0;
        end else if (beat) begin
            asm_d = asm_full[DESC_BITS-WORD_W-1:0];
            if (final_slot) begin
                beat_cnt_d = '0;
                if (!in_last) begin
                    err_frame_d = 1'b1;
                end else if (range_bad) begin
                    err_range_d = 1'b1;
                end else begin
                    push           = 1'b1;
                    accepted_cnt_d = accepted_cnt_q + 16'd1;
                end
            end else if (in_last) begin
                beat_cnt_d  = '0;
                err_frame_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q     <= '0;
            err_frame_q    <= 1'b0;
            err_range_q    <= 1'b0;
            accepted_cnt_q <= '0;
        end else begin
            beat_cnt_q     <= beat_cnt_d;
            err_frame_q    <= err_frame_d;
            err_range_q    <= err_range_d;
            accepted_cnt_q <= accepted_cnt_d;
        end
    end

    // Assembly register is always fully overwritten before use.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

    assign err_frame    = err_frame_q;
    assign err_range    = err_range_q;
    assign accepted_cnt = accepted_cnt_q;

    desc_fifo #(
        .WIDTH (DESC_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .push  (push),
        .pop   (pop),
        .din   (asm_full),
        .dout  (out_desc),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (occupancy)
    );

endmodule

// File: tb/tb_desc_queue.sv
// Bench for desc_queue: directed scenarios plus random descriptors on a
// 32-bit and a 64-bit instance, checked every cycle against a queue model.
module tb_desc_queue;
    import accelerator_common_pkg::*;

    localparam int DEPTH = 4;
    localparam int SRAM  = 32768;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, in_valid, in_last, out_ready, sel;
    logic [63:0] in_data;

    logic        r32, ov32, fe32, fr32, r64, ov64, fe64, fr64;
    logic [255:0] od32, od64;
    logic [2:0]  occ32, occ64;
    logic [15:0] acc32, acc64;

    desc_queue #(.WORD_W(32), .DEPTH(DEPTH), .SRAM_BYTES(SRAM)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid && !sel), .in_ready(r32), .in_data(in_data[31:0]), .in_last(in_last),
        .out_valid(ov32), .out_ready(out_ready && !sel), .out_desc(od32),
        .occupancy(occ32), .err_frame(fe32), .err_range(fr32), .accepted_cnt(acc32));

    desc_queue #(.WORD_W(64), .DEPTH(DEPTH), .SRAM_BYTES(SRAM)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid && sel), .in_ready(r64), .in_data(in_data), .in_last(in_last),
        .out_valid(ov64), .out_ready(out_ready && sel), .out_desc(od64),
        .occupancy(occ64), .err_frame(fe64), .err_range(fr64), .accepted_cnt(acc64));

    logic         in_ready_o, ov_o, fe_o, fr_o;
    logic [255:0] od_o;
    logic [2:0]   occ_o;
    logic [15:0]  acc_o;
    assign in_ready_o = sel ? r64 : r32;
    assign ov_o  = sel ? ov64 : ov32;
    assign fe_o  = sel ? fe64 : fe32;
    assign fr_o  = sel ? fr64 : fr32;
    assign od_o  = sel ? od64 : od32;
    assign occ_o = sel ? occ64 : occ32;
    assign acc_o = sel ? acc64 : acc32;

    // Reference model: beats of the partial descriptor and the stored queue.
    int           W, BEATS;
    logic [63:0]  part[$];
    logic [255:0] mq[$];
    int           acc;
    bit           ef, er;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] assemble();
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < BEATS; i++)
            for (int b = 0; b < W; b++)
                r[255 - i*W - b] = part[i][W-1-b];
        return r;
    endfunction

    function automatic bit range_ok(input logic [255:0] dsc);
        descriptor_t t;
        int sum;
        t = dsc;
        sum = int'(t.sram_addr) + int'(t.length);
        return (t.length != 16'd0) && (sum <= SRAM);
    endfunction

    function automatic logic [63:0] beat_of(input logic [255:0] dsc, input int i);
        logic [255:0] s;
        s = dsc >> (256 - (i + 1) * W);
        return (W == 64) ? s[63:0] : {32'b0, s[31:0]};
    endfunction

    function automatic logic [255:0] mk_desc(input logic [63:0] dram, input logic [15:0] sa,
                                             input logic [15:0] len);
        descriptor_t t;
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
        t = r;
        t.dram_addr = dram;
        t.sram_addr = sa;
        t.length    = len;
        return t;
    endfunction

    function automatic logic [255:0] good_desc();
        return mk_desc({$urandom, $urandom}, 16'($urandom_range(0, 16'h3FFF)),
                       16'($urandom_range(1, 16'h0FFF)));
    endfunction

    task automatic check_outputs();
        chk("out_valid", ov_o, mq.size() > 0);
        chk("occupancy", occ_o, mq.size());
        chk("err_frame", fe_o, ef);
        chk("err_range", fr_o, er);
        chk("accepted_cnt", acc_o, 16'(acc));
        if (mq.size() > 0) chk("out_desc", od_o, mq[0]);
    endtask

    task automatic step(input logic v, input logic [63:0] d, input logic l, input logic ordy);
        bit exp_rdy, xfer, popq;
        logic [255:0] dsc;
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = ordy;
        exp_rdy = (part.size() != BEATS - 1) || (mq.size() < DEPTH);
        #1;
        chk("in_ready", in_ready_o, exp_rdy);
        xfer = v && exp_rdy;
        popq = ordy && (mq.size() > 0);
        @(posedge clk);
        ef = 0;
        er = 0;
        if (rst) begin
            part.delete();
            mq.delete();
            acc = 0;
        end else if (flush) begin
            part.delete();
            mq.delete();
        end else begin
            if (popq) void'(mq.pop_front());
            if (xfer) begin
                part.push_back(d);
                if (part.size() == BEATS) begin
                    if (!l) ef = 1;
                    else begin
                        dsc = assemble();
                        if (range_ok(dsc)) begin
                            mq.push_back(dsc);
                            acc++;
                        end else er = 1;
                    end
                    part.delete();
                end else if (l) begin
                    ef = 1;
                    part.delete();
                end
            end
        end
        #1;
        check_outputs();
        $display("cyc v=%0b last=%0b ordy=%0b rst=%0b flush=%0b -> occ=%0d ef=%0b er=%0b acc=%0d",
                 v, l, ordy, rst, flush, occ_o, fe_o, fr_o, acc_o);
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) step(1'b0, 64'd0, 1'b0, ordy);
    endtask

    // omode: 0 hold low, 1 hold high, 2 random, 3 high only on the final beat.
    task automatic send_desc(input logic [255:0] dsc, input int nbeats, input bit last_on_final,
                             input int omode);
        for (int i = 0; i < nbeats; i++) begin
            int  tries;
            bit  done, will;
            logic o;
            tries = 0;
            done  = 0;
            while (!done && tries < 16) begin
                o = (omode == 1) || (omode == 2 && $urandom_range(1, 0) == 1) ||
                    (omode == 3 && i == nbeats - 1);
                will = (part.size() != BEATS - 1) || (mq.size() < DEPTH);
                step(1'b1, beat_of(dsc, i), last_on_final && (i == nbeats - 1), o);
                done = will;
                tries++;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $error("FAIL send_timeout: beat %0d not accepted after %0d cycles", i, tries);
            end
        end
    endtask

    task automatic rand_desc();
        int kind, nb;
        logic [255:0] dsc;
        logic [15:0]  len;
        len = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 16'h1000));
        dsc = mk_desc({$urandom, $urandom}, 16'($urandom_range(0, 16'h7FFF)), len);
        kind = $urandom_range(0, 7);
        if (kind == 0) begin
            nb = $urandom_range(1, BEATS - 1);
            send_desc(dsc, nb, 1, 2);
        end else if (kind == 1) begin
            send_desc(dsc, BEATS, 0, 2);
        end else begin
            send_desc(dsc, BEATS, 1, 2);
        end
    endtask

    logic [255:0] d;
    logic [255:0] ds[5];

    initial begin
        sel = 1'b0; W = 32; BEATS = 8; acc = 0;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        step(1'b0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("reset_in_ready", in_ready_o, 1);

        // Canonical 8-beat descriptor
        d = mk_desc(64'h8000_0000, 16'h0100, 16'h0040);
        send_desc(d, 8, 1, 0);
        chk("basic_valid", ov_o, 1);
        chk("basic_desc", od_o, d);
        idle(1, 1'b1);

        // Early in_last on beat 3
        send_desc(good_desc(), 4, 1, 0);
        chk("early_last_err", fe_o, 1);
        chk("early_last_occ", occ_o, 0);
        idle(1, 1'b0);
        chk("early_last_pulse_end", fe_o, 0);
        d = good_desc();
        send_desc(d, 8, 1, 0);
        chk("after_frame_desc", od_o, d);
        idle(1, 1'b1);

        // Missing in_last on final beat
        send_desc(good_desc(), 8, 0, 0);
        chk("missing_last_err", fe_o, 1);

        // Range checks
        send_desc(mk_desc(64'd1, 16'h7FF0, 16'h0020), 8, 1, 0);
        chk("range_over", fr_o, 1);
        chk("range_over_occ", occ_o, 0);
        send_desc(mk_desc(64'd2, 16'h0010, 16'h0000), 8, 1, 0);
        chk("range_zero_len", fr_o, 1);
        send_desc(mk_desc(64'd3, 16'h7FC0, 16'h0040), 8, 1, 0);
        chk("range_exact_end", fr_o, 0);
        chk("range_exact_occ", occ_o, 1);
        send_desc(mk_desc(64'd4, 16'hFFFF, 16'hFFFF), 8, 1, 0);
        chk("range_no_wrap", fr_o, 1);
        idle(2, 1'b1);

        // Simultaneous push and pop at occupancy 2, then flush mid-descriptor
        send_desc(good_desc(), 8, 1, 0);
        send_desc(good_desc(), 8, 1, 0);
        chk("pp_occ_before", occ_o, 2);
        send_desc(good_desc(), 8, 1, 3);
        chk("pp_occ_after", occ_o, 2);
        d = good_desc();
        for (int i = 0; i < 3; i++) step(1'b1, beat_of(d, i), 1'b0, 1'b0);
        flush = 1'b1;
        step(1'b1, beat_of(d, 3), 1'b0, 1'b1);
        flush = 1'b0;
        chk("flush_occ", occ_o, 0);
        chk("flush_no_err", fe_o, 0);
        d = good_desc();
        send_desc(d, 8, 1, 0);
        chk("post_flush_desc", od_o, d);

        // Reset mid-descriptor with two stored entries
        send_desc(good_desc(), 8, 1, 0);
        chk("prerst_occ", occ_o, 2);
        d = good_desc();
        for (int i = 0; i < 3; i++) step(1'b1, beat_of(d, i), 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;
        chk("rst_acc", acc_o, 0);
        chk("rst_valid", ov_o, 0);
        chk("rst_in_ready", in_ready_o, 1);

        for (int k = 0; k < 30; k++) rand_desc();
        idle(6, 1'b1);

        // Switch to the 64-bit instance
        sel = 1'b1; W = 64; BEATS = 4;
        part.delete(); mq.delete(); acc = 0;
        rst = 1'b1;
        step(1'b0, 64'd0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < 5; k++) ds[k] = good_desc();
        for (int k = 0; k < 4; k++) send_desc(ds[k], 4, 1, 0);
        chk("full_occ", occ_o, 4);
        for (int i = 0; i < 3; i++) step(1'b1, beat_of(ds[4], i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, beat_of(ds[4], 3), 1'b1, 1'b0);
        chk("full_stall_ready", in_ready_o, 0);
        chk("full_stall_occ", occ_o, 4);
        step(1'b1, beat_of(ds[4], 3), 1'b1, 1'b1);
        chk("full_pop_ready", in_ready_o, 1);
        chk("full_pop_occ", occ_o, 3);
        step(1'b1, beat_of(ds[4], 3), 1'b1, 1'b0);
        chk("fifth_occ", occ_o, 4);
        chk("fifth_acc", acc_o, 5);
        for (int k = 1; k < 5; k++) begin
            chk("order", od_o, ds[k]);
            step(1'b0, 64'd0, 1'b0, 1'b1);
        end

        for (int k = 0; k < 20; k++) rand_desc();
        idle(6, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/desc_queue.md
DESC_QUEUE -- requirements
Module: desc_queue

Interface
REQ-001 SHALL have parameter WORD_W, default 32: input beat width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter DEPTH, default 4: number of descriptor FIFO entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter SRAM_BYTES, default 32768: byte size of the target on-chip buffer, used for range checking.
REQ-004 SHALL have one clock, clk, with all state updating on its rising edge.
REQ-005 SHALL have port clk  input  1  the single clock.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port flush  input  1  synchronous clear of the queue and of any partial descriptor.
REQ-008 SHALL have port in_valid  input  1  an input beat is offered.
REQ-009 SHALL have port in_ready  output  1  the queue can accept a beat.
REQ-010 SHALL have port in_data  input  WORD_W  descriptor beat, most-significant beat first.
REQ-011 SHALL have port in_last  input  1  marks the final beat of a descriptor.
REQ-012 SHALL have port out_valid  output  1  a descriptor is available at the FIFO head.
REQ-013 SHALL have port out_ready  input  1  the consumer takes the head descriptor.
REQ-014 SHALL have port out_desc  output  256  head descriptor, typed descriptor_t.
REQ-015 SHALL have port occupancy  output  $clog2(DEPTH+1)  number of stored descriptors.
REQ-016 SHALL have port err_frame  output  1  one-cycle pulse on a framing error.
REQ-017 SHALL have port err_range  output  1  one-cycle pulse on a range error.
REQ-018 SHALL have port accepted_cnt  output  16  count of descriptors enqueued, wrapping.

Function
REQ-019 SHALL define BEATS = 256/WORD_W (8 for WORD_W=32, 4 for WORD_W=64); a beat transfers when in_valid and in_ready are both high.
REQ-020 SHALL shift each beat into a 256-bit assembly register, so the first beat lands in bits [255:256-WORD_W].
REQ-021 SHALL count beats with a counter that runs 0..BEATS-1 and returns to 0 after the final beat.
REQ-022 SHALL drive in_ready = (beat_cnt != BEATS-1) OR (occupancy < DEPTH), using registered state only, so there is no combinational path from out_ready to in_ready.
REQ-023 SHALL, on a final beat that passes both checks, write the assembled descriptor into the FIFO on the same edge; out_valid SHALL rise the cycle after that final beat.
REQ-024 SHALL treat in_last high on a beat before BEATS-1 as a framing error: discard the partial descriptor, clear beat_cnt to 0, pulse err_frame, and enqueue nothing.
REQ-025 SHALL treat in_last low on beat BEATS-1 as a framing error: drop the descriptor, pulse err_frame, and clear beat_cnt to 0.
REQ-026 SHALL treat a correctly framed descriptor with length==0, or with sram_addr+length > SRAM_BYTES, as a range error: drop it and pulse err_range.
REQ-027 SHALL compute the sram_addr+length sum in 17 bits so it never wraps.
REQ-028 SHALL pop the FIFO head when out_valid and out_ready are both high.
REQ-029 SHALL present out_desc directly from the FIFO head register, with no bubble between back-to-back entries.
REQ-030 SHALL, on a push and a pop in the same cycle, leave occupancy unchanged and keep FIFO order intact.
REQ-031 SHALL not push when full (guaranteed by REQ-022), even if a pop happens in that cycle.
REQ-032 SHALL increment accepted_cnt by 1 per enqueue, wrapping from 0xFFFF to 0x0000.
REQ-033 SHALL give flush priority over push and pop: FIFO emptied, beat_cnt=0, no error pulses that cycle; accepted_cnt is retained.
REQ-034 SHALL leave out_desc contents undefined while out_valid is low; the bench must not check out_desc then.

Reset
REQ-035 SHALL, on rst high at a clock edge, set out_valid=0, occupancy=0, beat_cnt=0, err_frame=0, err_range=0, accepted_cnt=0, and clear both FIFO pointers.
REQ-036 SHALL keep in_ready=1 after reset.
REQ-037 SHALL, when reset arrives mid-descriptor or mid-drain, discard all partial and stored descriptors.
REQ-038 SHALL not reset the storage arrays.

Structure
REQ-039 SHALL take descriptor_t, the FLAG_* bit positions and DATA_WIDTH from accelerator_common_pkg.
REQ-040 SHALL add DESC_BITS=256 to accelerator_common_pkg.
REQ-041 SHALL add DESC_BEATS_32=8 and DESC_BEATS_64=4 to accelerator_common_pkg.
REQ-042 SHALL place the FIFO in one sub-module, desc_fifo, parametrised by width and depth, with push, pop, full, empty and count ports.
REQ-043 SHALL keep beat assembly, framing checks and range checks in desc_queue itself.

Verification
REQ-044 SHALL cover: WORD_W=32, 8 beats with in_last on beat 7, dram_addr=0x8000_0000, sram_addr=0x0100, length=0x0040 -> out_valid one cycle after beat 7 and out_desc matches the input bit-for-bit.
REQ-045 SHALL cover: WORD_W=64, DEPTH=4, push 5 descriptors with out_ready=0 -> occupancy=4, in_ready low on the final beat of descriptor 5 until one pop, then descriptor 5 enqueues and FIFO order is preserved.
REQ-046 SHALL cover: in_last on beat 3 of 8 -> err_frame pulses for one cycle, nothing is enqueued, and the next 8-beat descriptor is accepted normally.
REQ-047 SHALL cover: sram_addr=0x7FF0, length=0x0020 with SRAM_BYTES=32768 -> err_range pulses and occupancy is unchanged; length=0 -> err_range pulses.
REQ-048 SHALL cover: occupancy=2 with a simultaneous final-beat push and pop -> occupancy stays 2; then flush during a partial descriptor -> occupancy=0 and the next descriptor assembles from beat 0.
REQ-049 SHALL cover: rst after 3 beats of a descriptor and 2 stored entries -> all outputs take their reset values the next cycle, and accepted_cnt=0.
